// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer and related multi-cycle units.
// Holds next-PC source encoding, instruction size and default vectors.
package pc_pkg;

    localparam int unsigned INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        PC_SEL_SEQ,
        PC_SEL_BRANCH,
        PC_SEL_JUMP,
        PC_SEL_TRAP
    } pc_sel_e;

    // Instruction fetches must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_stage_counter.sv
// Wrapping stage counter 0..NUM_STAGES-1 with a hold input.
// last_stage flags the final stage so callers can gate their commit.
module pc_stage_counter #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned WIDTH      = $clog2(NUM_STAGES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_stage_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             last_stage;

    assign last_stage = (count_q == WIDTH'(NUM_STAGES - 1));

    always_comb begin
        count_d = count_q;
        if (!hold_i) begin
            count_d = last_stage ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign last_stage_o = last_stage;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and stage sequencer for the multi-cycle core.
// The PC, trap state and retired counter update only on the final, unstalled stage.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     NUM_STAGES   = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          stall,
    input  logic                          branch_enable,
    input  logic                          jump_enable,
    input  logic                          trap_request,
    input  logic [XLEN-1:0]               immediate,
    input  logic [XLEN-1:0]               rs1_value,
    output logic [$clog2(NUM_STAGES)-1:0] stage,
    output logic [XLEN-1:0]               PC,
    output logic [XLEN-1:0]               PC_plus4,
    output logic [XLEN-1:0]               epc,
    output logic                          misaligned,
    output logic [31:0]                   retired_count
);

    localparam int unsigned STAGE_W = $clog2(NUM_STAGES);

    logic            last_stage;
    logic            commit;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            misaligned_q, misaligned_d;
    logic [31:0]     retired_q, retired_d;

    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] selected_target;
    logic            target_fault;
    pc_sel_e         pc_sel;

    pc_stage_counter #(
        .NUM_STAGES (NUM_STAGES),
        .WIDTH      (STAGE_W)
    ) u_stage_counter (
        .clk_i        (CLK),
        .rst_i        (Reset),
        .hold_i       (stall),
        .count_o      (stage),
        .last_stage_o (last_stage)
    );

    assign commit = last_stage & ~stall;

    assign seq_target    = pc_q + XLEN'(INSTR_BYTES);
    assign branch_target = pc_q + immediate;
    assign jump_target   = (rs1_value + immediate) & ~XLEN'(1);

    always_comb begin
        pc_sel = PC_SEL_SEQ;
        if (trap_request) begin
            pc_sel = PC_SEL_TRAP;
        end else if (jump_enable) begin
            pc_sel = PC_SEL_JUMP;
        end else if (branch_enable) begin
            pc_sel = PC_SEL_BRANCH;
        end
    end

    always_comb begin
        selected_target = seq_target;
        unique case (pc_sel)
            PC_SEL_SEQ:    selected_target = seq_target;
            PC_SEL_BRANCH: selected_target = branch_target;
            PC_SEL_JUMP:   selected_target = jump_target;
            PC_SEL_TRAP:   selected_target = TRAP_VECTOR;
            default:       selected_target = seq_target;
        endcase
    end

    // Only redirected targets can be misaligned; sequential and trap targets never are.
    assign target_fault = ((pc_sel == PC_SEL_BRANCH) || (pc_sel == PC_SEL_JUMP)) &&
                          is_misaligned(selected_target[1:0]);

    always_comb begin
        pc_d         = pc_q;
        epc_d        = epc_q;
        misaligned_d = misaligned_q;
        retired_d    = retired_q;
        if (commit) begin
            retired_d    = retired_q + 32'd1;
            misaligned_d = 1'b0;
            if (target_fault) begin
                pc_d         = TRAP_VECTOR;
                epc_d        = pc_q;
                misaligned_d = 1'b1;
            end else if (pc_sel == PC_SEL_TRAP) begin
                pc_d  = TRAP_VECTOR;
                epc_d = pc_q;
            end else begin
                pc_d = selected_target;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            misaligned_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            misaligned_q <= misaligned_d;
            retired_q    <= retired_d;
        end
    end

    assign PC            = pc_q;
    assign PC_plus4      = pc_q + XLEN'(INSTR_BYTES);
    assign epc           = epc_q;
    assign misaligned    = misaligned_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written corner
// sequences and a randomized run against an instruction-level reference model.
module tb_pc_sequencer;

    localparam int unsigned NS = 4;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_enable = 1'b0;
    logic        jump_enable = 1'b0;
    logic        trap_request = 1'b0;
    logic [31:0] immediate = '0;
    logic [31:0] rs1_value = '0;
    logic [1:0]  stage;
    logic [31:0] PC, PC_plus4, epc, retired_count;
    logic        misaligned;

    pc_sequencer #(
        .XLEN         (32),
        .NUM_STAGES   (NS),
        .RESET_VECTOR (32'h0),
        .TRAP_VECTOR  (TV)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .stall         (stall),
        .branch_enable (branch_enable),
        .jump_enable   (jump_enable),
        .trap_request  (trap_request),
        .immediate     (immediate),
        .rs1_value     (rs1_value),
        .stage         (stage),
        .PC            (PC),
        .PC_plus4      (PC_plus4),
        .epc           (epc),
        .misaligned    (misaligned),
        .retired_count (retired_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one instruction = NS unstalled cycles, effects applied at its end.
    int unsigned m_stage;
    logic [31:0] m_pc, m_epc, m_ret;
    logic        m_mis;

    task automatic model_reset();
        m_stage = 0;
        m_pc    = 32'h0;
        m_epc   = 32'h0;
        m_ret   = 32'h0;
        m_mis   = 1'b0;
    endtask

    task automatic model_finish_instr();
        logic [31:0] target;
        logic        redirect;
        m_ret = m_ret + 1;
        redirect = 1'b0;
        target = m_pc + 4;
        if (trap_request) begin
            m_epc = m_pc;
            m_pc  = TV;
            m_mis = 1'b0;
        end else begin
            if (jump_enable) begin
                target = rs1_value + immediate;
                if (target % 2 == 1) target = target - 1;
                redirect = 1'b1;
            end else if (branch_enable) begin
                target = m_pc + immediate;
                redirect = 1'b1;
            end
            if (redirect && (target % 4 != 0)) begin
                m_epc = m_pc;
                m_pc  = TV;
                m_mis = 1'b1;
            end else begin
                m_pc  = target;
                m_mis = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        if (Reset) begin
            model_reset();
        end else if (!stall) begin
            if (m_stage == NS - 1) model_finish_instr();
            m_stage = (m_stage + 1) % NS;
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check32({tag, " stage"}, {30'd0, stage}, m_stage);
        check32({tag, " PC"}, PC, m_pc);
        check32({tag, " PC_plus4"}, PC_plus4, m_pc + 32'd4);
        check32({tag, " epc"}, epc, m_epc);
        check32({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, m_mis});
        check32({tag, " retired"}, retired_count, m_ret);
    endtask

    task automatic clear_inputs();
        stall = 0; trap_request = 0; jump_enable = 0; branch_enable = 0;
        immediate = 0; rs1_value = 0;
    endtask

    // Runs one instruction from stage 0; controls are junk except on the commit cycle.
    task automatic run_instr(input logic tr, input logic jp, input logic br,
                             input logic [31:0] imm, input logic [31:0] rs1);
        while (m_stage != NS - 1) begin
            stall = 0;
            trap_request = 1'($urandom);
            jump_enable = 1'($urandom);
            branch_enable = 1'($urandom);
            immediate = $urandom;
            rs1_value = $urandom;
            cycle();
        end
        stall = 0; trap_request = tr; jump_enable = jp; branch_enable = br;
        immediate = imm; rs1_value = rs1;
        cycle();
        clear_inputs();
    endtask

    typedef struct {
        logic        tr, jp, br;
        logic [31:0] imm, rs1;
        logic [31:0] exp_pc, exp_epc;
        logic        exp_mis;
    } vec_t;

    vec_t vt[12];

    initial begin
        // tr jp br imm rs1 -> pc epc mis ; first entry starts at PC=4
        vt[0]  = '{0, 0, 0, 32'h0,         32'h0,         32'h8,         32'h0,   0};
        vt[1]  = '{0, 0, 0, 32'h0,         32'h0,         32'hC,         32'h0,   0};
        vt[2]  = '{0, 0, 1, 32'h14,        32'h0,         32'h20,        32'h0,   0};
        vt[3]  = '{0, 0, 1, 32'hFFFF_FFF0, 32'h0,         32'h10,        32'h0,   0};
        vt[4]  = '{0, 1, 0, 32'h4,         32'h101,       32'h104,       32'h0,   0};
        vt[5]  = '{0, 1, 0, 32'h6,         32'h101,       TV,            32'h104, 1};
        vt[6]  = '{0, 0, 1, 32'hFFFF_FF40, 32'h0,         32'h40,        32'h104, 0};
        vt[7]  = '{1, 1, 1, 32'h8,         32'h10,        TV,            32'h40,  0};
        vt[8]  = '{0, 0, 1, 32'h2,         32'h0,         TV,            32'h100, 1};
        vt[9]  = '{0, 0, 1, 32'hFFFF_FEFC, 32'h0,         32'hFFFF_FFFC, 32'h100, 0};
        vt[10] = '{0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h100, 0};
        vt[11] = '{0, 1, 0, 32'h21,        32'hFFFF_FFF0, 32'h10,        32'h100, 0};

        model_reset();
        @(posedge CLK);
        #1;
        check32("reset PC", PC, 32'h0);
        check32("reset PC_plus4", PC_plus4, 32'h4);
        check32("reset stage", {30'd0, stage}, 32'd0);
        check32("reset epc", epc, 32'h0);
        check32("reset retired", retired_count, 32'h0);
        Reset = 0;

        // First instruction: fetched from the reset vector, PC moves only after stage 3.
        for (int i = 1; i <= NS; i++) begin
            cycle();
            check32("seq stage", {30'd0, stage}, i % NS);
            check32("seq PC", PC, (i == NS) ? 32'h4 : 32'h0);
        end

        for (int i = 0; i < 12; i++) begin
            run_instr(vt[i].tr, vt[i].jp, vt[i].br, vt[i].imm, vt[i].rs1);
            check32($sformatf("vec%0d PC", i), PC, vt[i].exp_pc);
            check32($sformatf("vec%0d PC_plus4", i), PC_plus4, vt[i].exp_pc + 32'd4);
            check32($sformatf("vec%0d epc", i), epc, vt[i].exp_epc);
            check32($sformatf("vec%0d mis", i), {31'd0, misaligned}, {31'd0, vt[i].exp_mis});
            check32($sformatf("vec%0d retired", i), retired_count, 32'(i + 2));
            check32($sformatf("vec%0d stage", i), {30'd0, stage}, 32'd0);
        end

        // Branch enable pulsed in stage 1 only must be ignored.
        cycle();
        branch_enable = 1; immediate = 32'h40;
        cycle();
        clear_inputs();
        cycle();
        cycle();
        check32("pulse PC", PC, 32'h14);

        run_instr(0, 0, 1, 32'h1, 32'h0);
        check32("misbr PC", PC, TV);
        check32("misbr epc", epc, 32'h14);
        check32("misbr mis", {31'd0, misaligned}, 32'd1);

        // Stall five cycles on the commit stage; inputs during the stall are not taken.
        cycle(); cycle(); cycle();
        stall = 1; trap_request = 1; branch_enable = 1; immediate = 32'h8;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check32("stall stage", {30'd0, stage}, 32'd3);
            check32("stall PC", PC, TV);
        end
        clear_inputs();
        cycle();
        check32("unstall PC", PC, 32'h104);
        check32("unstall stage", {30'd0, stage}, 32'd0);
        check32("unstall mis", {31'd0, misaligned}, 32'd0);
        check32("unstall epc", epc, 32'h14);
        check32("unstall retired", retired_count, 32'd16);

        // Asynchronous reset in the middle of stage 2.
        cycle(); cycle();
        #2;
        Reset = 1;
        #1;
        check32("areset PC", PC, 32'h0);
        check32("areset stage", {30'd0, stage}, 32'd0);
        check32("areset epc", epc, 32'h0);
        check32("areset retired", retired_count, 32'h0);
        model_reset();
        cycle();
        Reset = 0;
        cycle();
        check32("release stage", {30'd0, stage}, 32'd1);
        cycle(); cycle(); cycle();
        check_model("post reset");

        // Retired counter wrap.
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFF_FFFF;
        check32("preload retired", retired_count, 32'hFFFF_FFFF);
        run_instr(0, 0, 0, 32'h0, 32'h0);
        check32("wrap retired", retired_count, 32'h0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(3) == 0);
            trap_request = ($urandom_range(9) == 0);
            jump_enable = ($urandom_range(4) == 0);
            branch_enable = ($urandom_range(2) == 0);
            immediate = $urandom;
            rs1_value = $urandom;
            if ($urandom_range(3) != 0) immediate[1:0] = 2'b00;
            if ($urandom_range(3) != 0) rs1_value[1:0] = 2'b00;
            cycle();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter and stage sequencer for the multi-cycle RISC-V core. It owns the instruction-stage counter and updates the PC once per instruction on the final stage. Next-PC sources are sequential, branch, JALR-style jump and trap vector. It adds stall, misalignment trapping, exception-PC capture and a retired-instruction counter, and sits between control unit, ALU operand path and instruction memory.

## Interface
- XLEN, 32, datapath/PC width
- NUM_STAGES, 4, stages per instruction; legal range 2..16
- RESET_VECTOR, 0, PC value after reset
- TRAP_VECTOR, 32'h0000_0100, PC target on trap
- CLK  in  1  clock; all state on rising edge
- Reset  in  1  reset, asynchronous and active-high
- stall  in  1  freeze the stage counter and PC this cycle
- branch_enable  in  1  take PC-relative branch at instruction end
- jump_enable  in  1  take register-relative jump at instruction end
- trap_request  in  1  redirect to TRAP_VECTOR at instruction end
- immediate  in  XLEN  sign-extended offset
- rs1_value  in  XLEN  jump base register
- stage  out  $clog2(NUM_STAGES)  current stage index
- PC  out  XLEN  current instruction address
- PC_plus4  out  XLEN  PC+4, used as the link value
- epc  out  XLEN  PC of the last trapping instruction
- misaligned  out  1  last redirect was a misaligned-target trap
- retired_count  out  32  instructions completed, wrapping

## Operation
- Stage counter counts 0..NUM_STAGES-1 and wraps to 0. It holds while stall=1.
- The commit edge is any rising edge with stage==NUM_STAGES-1 and stall=0. PC, epc, misaligned and retired_count change only on a commit edge.
- Control inputs and operands are sampled only on the commit edge. Their values at other times are ignored.
- Candidate targets:
  - seq = PC+4
  - branch = PC+immediate
  - jump = (rs1_value+immediate) with bit 0 cleared
- Select priority: trap_request > jump_enable > branch_enable > seq. Multiple enables asserted together resolve by this priority, with no error.
- Misalignment check: if the selected jump or branch target has bits[1:0] != 0, the PC loads TRAP_VECTOR instead, misaligned is set to 1 and epc loads the current PC.
- trap_request loads TRAP_VECTOR, sets epc to the current PC and clears misaligned.
- Any non-trapping commit clears misaligned. epc holds its value.
- retired_count increments by 1 on every commit edge, including trapping ones, and wraps 2^32-1 -> 0.
- All PC arithmetic is modulo 2^XLEN, with no overflow detection. For example, PC=FFFF_FFFC sequential gives 0.
- PC_plus4 is combinational from PC.

## Timing
- Reset, whether asserted or mid-instruction, takes effect immediately and asynchronously:
  - PC=RESET_VECTOR, stage=0, epc=0, misaligned=0, retired_count=0
  - the first instruction fetches from RESET_VECTOR directly, with no pre-decrement
- On release, stage advances on the first rising edge with Reset=0.
- Without stalls, an instruction takes NUM_STAGES cycles. The new PC is visible one cycle after the commit edge, coincident with stage=0.
- A stall asserted on the commit-stage cycle delays the commit by one cycle per stalled cycle. Inputs are resampled on the actual commit edge.
- A stall in a non-final stage freezes the stage and leaves the PC unchanged.

## Structure
- Shared package pc_pkg holds:
  - next-PC select enum PC_SEL_SEQ, PC_SEL_BRANCH, PC_SEL_JUMP, PC_SEL_TRAP
  - INSTR_BYTES=4
  - default RESET_VECTOR and TRAP_VECTOR constants
- One sub-module, pc_stage_counter: parametrised wrapping counter with hold input and a last_stage output, reused by other multi-cycle units.
- Target adders, priority select and misalignment check stay inline in pc_sequencer.

## Test plan
- Reset, then 3 instructions with NUM_STAGES=4 and no enables -> PC 0,4,8,C changes exactly every 4 cycles, stage sequence 0,1,2,3,0, retired_count=3.
- At PC=0x20, branch_enable=1, immediate=0xFFFF_FFF0 on the commit edge -> PC=0x10; a branch enable pulsed in stage 1 only is ignored.
- jump_enable=1 with rs1_value=0x101 and immediate=0x4 -> PC=0x104 (bit 0 cleared); same case with immediate=0x6 -> PC=TRAP_VECTOR, misaligned=1, epc equals the old PC.
- trap_request, jump_enable and branch_enable all set together at PC=0x40 -> PC=0x100, epc=0x40, misaligned=0.
- stall held 5 cycles at stage 3 -> PC and stage are frozen and the commit happens on the first edge after stall drops; Reset pulsed mid-stage 2 -> all outputs return to reset values asynchronously, before the next clock edge.
- PC preloaded via branch to 0xFFFF_FFFC with a sequential step -> PC=0; retired_count forced to wrap from 0xFFFF_FFFF -> 0.
